// File: rtl/note_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | note_sequencer: manual / auto-play / guided tone player with scoring  |
// | Revision 1.0                                                           |
// +------------------------------------------------------------------------+
module note_sequencer #(
  parameter int NUM_KEYS    = 8,
  parameter int NUM_SONGS   = 2,
  parameter int SONG_LEN    = 32,
  parameter int BEAT_CYCLES = 25_000_000,
  parameter int DIV_W       = 18,
  localparam int SEL_W      = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1,
  localparam int ADDR_W     = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1,
  localparam int KEY_W      = $clog2(NUM_KEYS + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [1:0]              mode_i,
  input  logic                    start_i,
  input  logic [SEL_W-1:0]        song_sel_i,
  input  logic [NUM_KEYS-1:0]     keys_i,
  output logic [SEL_W+ADDR_W-1:0] rom_addr_o,
  input  logic [KEY_W:0]          rom_data_i,
  output logic [KEY_W-1:0]        pitch_idx_o,
  input  logic [DIV_W-1:0]        pitch_hp_i,
  output logic                    freq_o,
  output logic [NUM_KEYS-1:0]     led_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [7:0]              hits_o,
  output logic [7:0]              misses_o
);

  localparam int BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(SONG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MANUAL, S_FETCH, S_WAIT, S_PLAY, S_GUIDE_WAIT, S_GUIDE_HOLD, S_REST
  } state_e;

  state_e              state_q, state_d;
  logic                start_q, keys_any_q;
  logic [1:0]          mode_q, mode_d;
  logic [SEL_W-1:0]    song_q, song_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [KEY_W-1:0]    note_q, note_d, press_q, press_d, pitch_prev_q;
  logic                last_q, last_d, hit_q, hit_d, freq_q, freq_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [7:0]          hits_q, hits_d, misses_q, misses_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d, cnt_eff;
  logic [KEY_W-1:0]    key_code, pitch;
  logic [NUM_KEYS-1:0] led;
  logic                busy, abort, finish, advance, done, changed;

  function automatic logic [NUM_KEYS-1:0] one_hot(input logic [KEY_W-1:0] code);
    logic [NUM_KEYS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_KEYS; i++) v[i] = (code == KEY_W'(i + 1));
    return v;
  endfunction

  // Lowest set key wins; code 0 means no key.
  always_comb begin
    key_code = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (keys_i[i]) key_code = KEY_W'(i + 1);
  end

  always_comb begin
    state_d  = state_q;  mode_d   = mode_q;   song_d  = song_q;  idx_d  = idx_q;
    note_d   = note_q;   last_d   = last_q;   beat_d  = beat_q;  hit_d  = hit_q;
    hits_d   = hits_q;   misses_d = misses_q; press_d = press_q;
    advance  = 1'b0;
    busy     = (state_q != S_IDLE) && (state_q != S_MANUAL);
    abort    = busy && (mode_i != mode_q);
    finish   = last_q || (idx_q == IDX_LAST);
    case (state_q)
      S_IDLE: begin
        if (mode_i == 2'b01) begin
          state_d = S_MANUAL;
        end else if (mode_i[1] && start_i && !start_q) begin
          state_d  = S_FETCH;
          mode_d   = mode_i;
          song_d   = song_sel_i;
          idx_d    = '0;
          note_d   = '0;
          last_d   = 1'b0;
          hits_d   = '0;
          misses_d = '0;
        end
      end
      S_MANUAL: if (mode_i != 2'b01) state_d = S_IDLE;
      S_FETCH:  state_d = S_WAIT;
      S_WAIT: begin
        note_d = rom_data_i[KEY_W-1:0];
        last_d = rom_data_i[KEY_W];
        beat_d = '0;
        if (!mode_q[0])                        state_d = S_PLAY;
        else if (rom_data_i[KEY_W-1:0] == '0)  state_d = S_REST;
        else                                   state_d = S_GUIDE_WAIT;
      end
      S_PLAY, S_REST: begin
        beat_d = beat_q + BEAT_W'(1);
        if (beat_q == BEAT_LAST) advance = 1'b1;
      end
      S_GUIDE_WAIT: begin
        if ((|keys_i) && !keys_any_q) begin
          press_d = key_code;
          hit_d   = (key_code == note_q);
          if (key_code == note_q) begin
            if (hits_q != 8'hFF) hits_d = hits_q + 8'd1;
          end else if (misses_q != 8'hFF) begin
            misses_d = misses_q + 8'd1;
          end
          state_d = S_GUIDE_HOLD;
        end
      end
      S_GUIDE_HOLD: begin
        if (!(|keys_i)) begin
          if (hit_q) advance = 1'b1;
          else       state_d = S_GUIDE_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (advance) begin
      if (finish) begin
        state_d = S_IDLE;
      end else begin
        idx_d   = idx_q + ADDR_W'(1);
        state_d = S_FETCH;
      end
    end
    done = advance && finish && !abort;
    if (abort) state_d = S_IDLE;
  end

  // During the FETCH/WAIT gap the LED keeps showing the previous note.
  always_comb begin
    pitch = '0;
    led   = '0;
    case (state_q)
      S_MANUAL:                      begin pitch = key_code; led = one_hot(key_code); end
      S_PLAY:                        begin pitch = note_q;   led = one_hot(note_q);   end
      S_GUIDE_HOLD:                  begin pitch = press_q;  led = one_hot(note_q);   end
      S_FETCH, S_WAIT, S_GUIDE_WAIT: led = one_hot(note_q);
      default: ;
    endcase
  end

  // The cycle a pitch appears counts as count 0, so the first toggle lands PITCH_HP cycles later.
  always_comb begin
    changed = (pitch != pitch_prev_q);
    cnt_eff = changed ? '0 : cnt_q;
    cnt_d   = cnt_eff + DIV_W'(1);
    freq_d  = changed ? 1'b0 : freq_q;
    if ((pitch == '0) || (pitch_hp_i == '0)) begin
      cnt_d  = '0;
      freq_d = 1'b0;
    end else if (cnt_eff == pitch_hp_i - DIV_W'(1)) begin
      cnt_d  = '0;
      freq_d = ~freq_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b1;
      keys_any_q   <= 1'b0;
      mode_q       <= '0;
      song_q       <= '0;
      idx_q        <= '0;
      note_q       <= '0;
      last_q       <= 1'b0;
      beat_q       <= '0;
      hit_q        <= 1'b0;
      press_q      <= '0;
      hits_q       <= '0;
      misses_q     <= '0;
      pitch_prev_q <= '0;
      cnt_q        <= '0;
      freq_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_i;
      keys_any_q   <= |keys_i;
      mode_q       <= mode_d;
      song_q       <= song_d;
      idx_q        <= idx_d;
      note_q       <= note_d;
      last_q       <= last_d;
      beat_q       <= beat_d;
      hit_q        <= hit_d;
      press_q      <= press_d;
      hits_q       <= hits_d;
      misses_q     <= misses_d;
      pitch_prev_q <= pitch;
      cnt_q        <= cnt_d;
      freq_q       <= freq_d;
    end
  end

  assign rom_addr_o  = {song_q, idx_q};
  assign pitch_idx_o = pitch;
  assign freq_o      = freq_q & (|pitch);
  assign led_o       = led;
  assign busy_o      = busy;
  assign done_o      = done;
  assign hits_o      = hits_q;
  assign misses_o    = misses_q;

endmodule
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`default_nettype none
// tb_note_sequencer: directed self-checking bench for note_sequencer.
module tb_note_sequencer;
  localparam int NUM_KEYS = 8, NUM_SONGS = 2, SONG_LEN = 8, BEAT_CYCLES = 10, DIV_W = 18;
  localparam int SEL_W = 1, ADDR_W = 3, KEY_W = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [1:0]              mode;
  logic                    start;
  logic [SEL_W-1:0]        song_sel;
  logic [NUM_KEYS-1:0]     keys;
  logic [SEL_W+ADDR_W-1:0] rom_addr;
  logic [KEY_W:0]          rom_data;
  logic [KEY_W-1:0]        pitch_idx;
  logic [DIV_W-1:0]        pitch_hp;
  logic                    freq;
  logic [NUM_KEYS-1:0]     led;
  logic                    busy, done;
  logic [7:0]              hits, misses;
  logic [KEY_W:0]          rom [0:15];
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];
  assign pitch_hp = DIV_W'(4) + DIV_W'(pitch_idx);

  note_sequencer #(
    .NUM_KEYS(NUM_KEYS), .NUM_SONGS(NUM_SONGS), .SONG_LEN(SONG_LEN),
    .BEAT_CYCLES(BEAT_CYCLES), .DIV_W(DIV_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .start_i(start), .song_sel_i(song_sel),
    .keys_i(keys), .rom_addr_o(rom_addr), .rom_data_i(rom_data), .pitch_idx_o(pitch_idx),
    .pitch_hp_i(pitch_hp), .freq_o(freq), .led_o(led), .busy_o(busy), .done_o(done),
    .hits_o(hits), .misses_o(misses)
  );

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 2'b00; start = 1'b0; song_sel = '0; keys = '0;
    cyc(3);
    checks++;
    if ({rom_addr, pitch_idx, freq, led, busy, done, hits, misses} !== 35'd0)
      $display("FAIL reset_outputs: got %h required 0",
               {rom_addr, pitch_idx, freq, led, busy, done, hits, misses});
    else passed++;
    rst_n = 1'b1;
    cyc(2);
    checks++;
    if (busy !== 1'b0 || pitch_idx !== 4'd0)
      $display("FAIL reset_release_idle: got busy=%b pitch=%0d required 0/0", busy, pitch_idx);
    else passed++;
  endtask

  task automatic test_manual();
    int errs;
    mode = 2'b01;
    cyc();
    keys = 8'b0010_0100;
    #1;
    checks++;
    if (pitch_idx !== 4'd3) $display("FAIL manual_pitch: got %0d required 3", pitch_idx);
    else passed++;
    checks++;
    if (led !== 8'b0000_0100) $display("FAIL manual_led: got %b required 00000100", led);
    else passed++;
    errs = 0;
    for (int n = 1; n <= 28; n++) begin
      cyc();
      if (freq !== 1'((n / 7) % 2)) errs++;
    end
    checks++;
    if (errs != 0) $display("FAIL manual_freq_period14: got %0d wrong samples required 0", errs);
    else passed++;
    keys = '0;
    cyc(2);
    checks++;
    if (freq !== 1'b0 || pitch_idx !== 4'd0)
      $display("FAIL manual_silent: got freq=%b pitch=%0d required 0/0", freq, pitch_idx);
    else passed++;
    mode = 2'b00;
    cyc(2);
  endtask

  task automatic test_auto();
    logic [3:0] ep;
    logic [7:0] el;
    logic       eb, ed;
    int         dones;
    rom[0] = 5'b0_0001; rom[1] = 5'b0_0000; rom[2] = 5'b1_0101;
    mode = 2'b10; song_sel = 1'b0; start = 1'b1;
    dones = 0;
    for (int n = 1; n <= 40; n++) begin
      cyc();
      if (n == 1) start = 1'b0;
      ep = 4'd0; el = 8'h00; eb = (n <= 36); ed = (n == 36);
      if (n >= 3 && n <= 12)        begin ep = 4'd1; el = 8'h01; end
      else if (n == 13 || n == 14)  el = 8'h01;
      else if (n >= 27 && n <= 36)  begin ep = 4'd5; el = 8'h10; end
      dones += int'(done);
      checks++;
      if ({pitch_idx, led, busy, done} !== {ep, el, eb, ed})
        $display("FAIL auto_cycle_%0d: got pitch=%0d led=%b busy=%b done=%b required %0d/%b/%b/%b",
                 n, pitch_idx, led, busy, done, ep, el, eb, ed);
      else passed++;
      if (n == 25) begin
        checks++;
        if (rom_addr !== 4'd2) $display("FAIL auto_fetch_addr: got %0d required 2", rom_addr);
        else passed++;
      end
      if (n == 20) begin
        checks++;
        if (freq !== 1'b0) $display("FAIL auto_rest_silent: got %b required 0", freq);
        else passed++;
      end
    end
    checks++;
    if (dones != 1) $display("FAIL auto_done_count: got %0d required 1", dones);
    else passed++;
    mode = 2'b00;
    cyc();
  endtask

  task automatic test_guide();
    rom[8] = 5'b0_0011; rom[9] = 5'b1_0100;
    mode = 2'b11; song_sel = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if (rom_addr !== 4'b1000) $display("FAIL guide_fetch_addr: got %b required 1000", rom_addr);
    else passed++;
    cyc(2);
    checks++;
    if (led !== 8'h04 || pitch_idx !== 4'd0)
      $display("FAIL guide_wait_led: got led=%b pitch=%0d required 00000100/0", led, pitch_idx);
    else passed++;
    keys = 8'b0010_0000;
    cyc();
    checks++;
    if (misses !== 8'd1 || hits !== 8'd0)
      $display("FAIL guide_miss_score: got hits=%0d misses=%0d required 0/1", hits, misses);
    else passed++;
    checks++;
    if (pitch_idx !== 4'd6) $display("FAIL guide_hold_pitch: got %0d required 6", pitch_idx);
    else passed++;
    keys = '0;
    cyc();
    checks++;
    if (led !== 8'h04 || busy !== 1'b1 || rom_addr !== 4'b1000)
      $display("FAIL guide_same_note: got led=%b busy=%b addr=%b required 00000100/1/1000",
               led, busy, rom_addr);
    else passed++;
    keys = 8'b0000_0100;
    cyc();
    checks++;
    if (hits !== 8'd1 || misses !== 8'd1)
      $display("FAIL guide_hit_score: got hits=%0d misses=%0d required 1/1", hits, misses);
    else passed++;
    keys = '0;
    cyc(3);
    checks++;
    if (led !== 8'h08 || rom_addr !== 4'b1001)
      $display("FAIL guide_advance: got led=%b addr=%b required 00001000/1001", led, rom_addr);
    else passed++;
    keys = 8'b0000_1000;
    cyc();
    checks++;
    if (hits !== 8'd2) $display("FAIL guide_hit2: got %0d required 2", hits);
    else passed++;
    keys = '0;
    #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b1)
      $display("FAIL guide_done_pulse: got done=%b busy=%b required 1/1", done, busy);
    else passed++;
    cyc();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || hits !== 8'd2)
      $display("FAIL guide_idle_after: got done=%b busy=%b hits=%0d required 0/0/2", done, busy, hits);
    else passed++;
    mode = 2'b00;
    cyc();
  endtask

  task automatic test_abort_start();
    mode = 2'b10; song_sel = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(3);
    start = 1'b1; song_sel = 1'b1;
    cyc();
    checks++;
    if (pitch_idx !== 4'd1 || rom_addr !== 4'd0 || busy !== 1'b1)
      $display("FAIL start_while_busy_ignored: got pitch=%0d addr=%0d busy=%b required 1/0/1",
               pitch_idx, rom_addr, busy);
    else passed++;
    mode = 2'b01;
    #1;
    checks++;
    if (done !== 1'b0) $display("FAIL abort_no_done: got %b required 0", done);
    else passed++;
    cyc();
    checks++;
    if (busy !== 1'b0 || freq !== 1'b0 || pitch_idx !== 4'd0 || done !== 1'b0)
      $display("FAIL abort_idle: got busy=%b freq=%b pitch=%0d done=%b required 0/0/0/0",
               busy, freq, pitch_idx, done);
    else passed++;
    keys = 8'b0000_0010;
    cyc();
    checks++;
    if (pitch_idx !== 4'd2 || led !== 8'h02)
      $display("FAIL abort_then_manual: got pitch=%0d led=%b required 2/00000010", pitch_idx, led);
    else passed++;
    keys = '0; mode = 2'b00; start = 1'b0; song_sel = 1'b0;
    cyc(2);
  endtask

  task automatic test_no_last();
    int done_cnt, done_at;
    for (int a = 8; a < 16; a++) rom[a] = 5'b0_0010;
    mode = 2'b10; song_sel = 1'b1; start = 1'b1;
    done_cnt = 0; done_at = 0;
    for (int n = 1; n <= 110; n++) begin
      cyc();
      if (n == 1) start = 1'b0;
      if (done === 1'b1) begin done_cnt++; done_at = n; end
    end
    checks++;
    if (done_cnt != 1) $display("FAIL nolast_done_count: got %0d required 1", done_cnt);
    else passed++;
    checks++;
    if (done_at != 96) $display("FAIL nolast_done_cycle: got %0d required 96", done_at);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL nolast_idle: got busy=%b required 0", busy);
    else passed++;
    mode = 2'b00;
    cyc();
  endtask

  task automatic test_saturation();
    rom[8] = 5'b0_0011; rom[9] = 5'b1_0100;
    mode = 2'b11; song_sel = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(2);
    for (int i = 0; i < 254; i++) begin keys = 8'h01; cyc(); keys = '0; cyc(); end
    checks++;
    if (misses !== 8'd254) $display("FAIL sat_254: got %0d required 254", misses);
    else passed++;
    for (int i = 0; i < 46; i++) begin keys = 8'h01; cyc(); keys = '0; cyc(); end
    checks++;
    if (misses !== 8'd255 || hits !== 8'd0)
      $display("FAIL sat_300_misses: got misses=%0d hits=%0d required 255/0", misses, hits);
    else passed++;
    mode = 2'b00;
    cyc();
    checks++;
    if (busy !== 1'b0 || misses !== 8'd255)
      $display("FAIL abort_scores_held: got busy=%b misses=%0d required 0/255", busy, misses);
    else passed++;
  endtask

  task automatic test_reset_mid();
    mode = 2'b10; song_sel = 1'b0; start = 1'b1;
    cyc(9);
    checks++;
    if (freq !== 1'b1 || busy !== 1'b1 || led !== 8'h01)
      $display("FAIL pre_reset_note: got freq=%b busy=%b led=%b required 1/1/00000001", freq, busy, led);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (freq !== 1'b0 || busy !== 1'b0 || led !== 8'h00 || pitch_idx !== 4'd0)
      $display("FAIL reset_mid_outputs: got freq=%b busy=%b led=%b pitch=%0d required 0/0/0/0",
               freq, busy, led, pitch_idx);
    else passed++;
    cyc(2);
    rst_n = 1'b1;
    cyc(4);
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_stays_idle: got busy=%b required 0", busy);
    else passed++;
    start = 1'b0;
    cyc();
    start = 1'b1;
    cyc();
    checks++;
    if (busy !== 1'b1) $display("FAIL fresh_start: got busy=%b required 1", busy);
    else passed++;
    start = 1'b0; mode = 2'b00;
    cyc(2);
  endtask

  initial begin
    for (int a = 0; a < 16; a++) rom[a] = '0;
    test_reset();
    test_manual();
    test_auto();
    test_guide();
    test_abort_start();
    test_no_last();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
